// File: rtl/he_lb_csr_responder.sv
// he_lb_csr_responder
// MMIO responder for the HE-LB CSR window (0x000-0x178). Accepts one host
// request at a time. Read completions go out through a single-entry response
// buffer one cycle after accept. The block holds the engine configuration
// registers, drives start/stop strobes and captures engine status and error.
module he_lb_csr_responder #(
    parameter int          ADDR_W   = 12,
    parameter int          TAG_W    = 10,
    parameter logic [63:0] DFH_VAL  = 64'h1000_0000_0000_1000,
    parameter logic [63:0] ID_L_VAL = 64'h0000_0000_0000_0000,
    parameter logic [63:0] ID_H_VAL = 64'h0000_0000_0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic              i_req_dw,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [63:0]       i_req_wdata,
    input  logic [TAG_W-1:0]  i_req_tag,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [63:0]       o_rsp_data,
    output logic [TAG_W-1:0]  o_rsp_tag,
    input  logic              i_eng_busy,
    input  logic [63:0]       i_eng_status0,
    input  logic [63:0]       i_eng_status1,
    input  logic              i_eng_err,
    output logic              o_ctl_rst_n,
    output logic              o_start_pulse,
    output logic              o_stop_pulse,
    output logic [63:0]       o_cfg_src,
    output logic [63:0]       o_cfg_dst,
    output logic [19:0]       o_cfg_lines,
    output logic [31:0]       o_cfg_cfg,
    output logic [31:0]       o_cfg_stride
);

    // CSR byte offsets
    localparam logic [ADDR_W-1:0] A_DFH    = ADDR_W'(12'h000);
    localparam logic [ADDR_W-1:0] A_ID_L   = ADDR_W'(12'h008);
    localparam logic [ADDR_W-1:0] A_ID_H   = ADDR_W'(12'h010);
    localparam logic [ADDR_W-1:0] A_SCR0   = ADDR_W'(12'h100);
    localparam logic [ADDR_W-1:0] A_SCR1   = ADDR_W'(12'h104);
    localparam logic [ADDR_W-1:0] A_SCR2   = ADDR_W'(12'h108);
    localparam logic [ADDR_W-1:0] A_DSM_L  = ADDR_W'(12'h110);
    localparam logic [ADDR_W-1:0] A_DSM_H  = ADDR_W'(12'h114);
    localparam logic [ADDR_W-1:0] A_SRC    = ADDR_W'(12'h120);
    localparam logic [ADDR_W-1:0] A_DST    = ADDR_W'(12'h128);
    localparam logic [ADDR_W-1:0] A_LINES  = ADDR_W'(12'h130);
    localparam logic [ADDR_W-1:0] A_CTL    = ADDR_W'(12'h138);
    localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'(12'h140);
    localparam logic [ADDR_W-1:0] A_INACT  = ADDR_W'(12'h148);
    localparam logic [ADDR_W-1:0] A_INTR   = ADDR_W'(12'h150);
    localparam logic [ADDR_W-1:0] A_SWTEST = ADDR_W'(12'h158);
    localparam logic [ADDR_W-1:0] A_STAT0  = ADDR_W'(12'h160);
    localparam logic [ADDR_W-1:0] A_STAT1  = ADDR_W'(12'h168);
    localparam logic [ADDR_W-1:0] A_ERR    = ADDR_W'(12'h170);
    localparam logic [ADDR_W-1:0] A_STRIDE = ADDR_W'(12'h178);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } state_t;

    // Merge a write into a 64-bit register: 8B replaces everything,
    // 4B replaces only the half chosen by addr[2].
    function automatic logic [63:0] merge64(
        input logic [63:0] old_val,
        input logic [63:0] wdata,
        input logic        dw,
        input logic        hi
    );
        logic [63:0] res;
        if (!dw) begin
            res = wdata;
        end else if (hi) begin
            res = {wdata[31:0], old_val[31:0]};
        end else begin
            res = {old_val[63:32], wdata[31:0]};
        end
        return res;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [63:0]        r_rsp_data;
    logic [TAG_W-1:0]   r_rsp_tag;

    logic [31:0]        r_scr0, r_scr1, r_scr2, r_dsm_l, r_dsm_h;
    logic [63:0]        r_src, r_dst, r_lines, r_ctl, r_cfg;
    logic [63:0]        r_inact, r_intr, r_swtest, r_stride;
    logic               r_err;
    logic               r_start, r_stop;

    logic               w_acc, w_wr, w_rd, w_hi, w_bad8, w_wr_ok, w_err_clr;
    logic [ADDR_W-1:0]  w_dword, w_qword;
    logic [63:0]        w_q;
    logic               w_q_hit;
    logic [63:0]        w_rd_val;
    logic               w_unused;

    assign w_acc     = i_req_valid & r_req_ready;
    assign w_wr      = w_acc & i_req_write;
    assign w_rd      = w_acc & ~i_req_write;
    assign w_hi      = i_req_addr[2];
    assign w_bad8    = ~i_req_dw & w_hi;
    assign w_wr_ok   = w_wr & ~w_bad8;
    assign w_dword   = {i_req_addr[ADDR_W-1:2], 2'b00};
    assign w_qword   = {i_req_addr[ADDR_W-1:3], 3'b000};
    assign w_err_clr = w_wr_ok & (w_qword == A_ERR) & ~w_hi & i_req_wdata[0];
    assign w_unused  = ^i_req_addr[1:0];

    // Select the 64-bit register addressed by the qword offset
    always_comb begin
        w_q     = 64'h0;
        w_q_hit = 1'b1;
        case (w_qword)
            A_DFH:    w_q = DFH_VAL;
            A_ID_L:   w_q = ID_L_VAL;
            A_ID_H:   w_q = ID_H_VAL;
            A_SRC:    w_q = r_src;
            A_DST:    w_q = r_dst;
            A_LINES:  w_q = r_lines;
            A_CTL:    w_q = r_ctl;
            A_CFG:    w_q = r_cfg;
            A_INACT:  w_q = r_inact;
            A_INTR:   w_q = r_intr;
            A_SWTEST: w_q = r_swtest;
            A_STAT0:  w_q = i_eng_status0;
            A_STAT1:  w_q = i_eng_status1;
            A_ERR:    w_q = {63'h0, r_err};
            A_STRIDE: w_q = r_stride;
            default: begin
                w_q     = 64'h0;
                w_q_hit = 1'b0;
            end
        endcase
    end

    // Form read data: 32-bit regs by dword, else 64-bit reg (or one half)
    always_comb begin
        w_rd_val = 64'h0;
        if (w_bad8) begin
            w_rd_val = 64'h0;
        end else begin
            case (w_dword)
                A_SCR0:  w_rd_val = {32'h0, r_scr0};
                A_SCR1:  w_rd_val = {32'h0, r_scr1};
                A_SCR2:  w_rd_val = {32'h0, r_scr2};
                A_DSM_L: w_rd_val = {32'h0, r_dsm_l};
                A_DSM_H: w_rd_val = {32'h0, r_dsm_h};
                default: begin
                    if (!w_q_hit) begin
                        w_rd_val = 64'h0;
                    end else if (!i_req_dw) begin
                        w_rd_val = w_q;
                    end else if (w_hi) begin
                        w_rd_val = {32'h0, w_q[63:32]};
                    end else begin
                        w_rd_val = {32'h0, w_q[31:0]};
                    end
                end
            endcase
        end
    end

    // Response FSM: state register plus registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RSP);
        end
    end

    // Next state: a read moves to RSP, host acceptance returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rd) begin
                    w_state_nxt = ST_RSP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RSP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Response buffer: capture data and tag when a read is accepted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_data <= 64'h0;
            r_rsp_tag  <= '0;
        end else if (w_rd) begin
            r_rsp_data <= w_rd_val;
            r_rsp_tag  <= i_req_tag;
        end
    end

    // CSR write path, control strobes and sticky error flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scr0   <= 32'h0;
            r_scr1   <= 32'h0;
            r_scr2   <= 32'h0;
            r_dsm_l  <= 32'h0;
            r_dsm_h  <= 32'h0;
            r_src    <= 64'h0;
            r_dst    <= 64'h0;
            r_lines  <= 64'h0;
            r_ctl    <= 64'h0;
            r_cfg    <= 64'h0;
            r_inact  <= 64'h0;
            r_intr   <= 64'h0;
            r_swtest <= 64'h0;
            r_stride <= 64'h0;
            r_err    <= 1'b0;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            // a new error event takes priority over a same-cycle clear
            if (i_eng_err) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_wr_ok) begin
                case (w_dword)
                    A_SCR0:  r_scr0  <= i_req_wdata[31:0];
                    A_SCR1:  r_scr1  <= i_req_wdata[31:0];
                    A_SCR2:  r_scr2  <= i_req_wdata[31:0];
                    A_DSM_L: r_dsm_l <= i_req_wdata[31:0];
                    A_DSM_H: r_dsm_h <= i_req_wdata[31:0];
                    default: begin
                    end
                endcase
                case (w_qword)
                    A_SRC: begin
                        if (!i_eng_busy) r_src <= merge64(r_src, i_req_wdata, i_req_dw, w_hi);
                    end
                    A_DST: begin
                        if (!i_eng_busy) r_dst <= merge64(r_dst, i_req_wdata, i_req_dw, w_hi);
                    end
                    A_LINES: begin
                        if (!i_eng_busy) r_lines <= merge64(r_lines, i_req_wdata, i_req_dw, w_hi);
                    end
                    A_CFG: begin
                        if (!i_eng_busy) r_cfg <= merge64(r_cfg, i_req_wdata, i_req_dw, w_hi);
                    end
                    A_STRIDE: begin
                        if (!i_eng_busy) r_stride <= merge64(r_stride, i_req_wdata, i_req_dw, w_hi);
                    end
                    A_CTL: begin
                        // strobe bits [2:1] are never stored
                        r_ctl <= merge64(r_ctl, i_req_wdata, i_req_dw, w_hi) &
                                 ~64'h0000_0000_0000_0006;
                        if (!w_hi) begin
                            r_start <= i_req_wdata[1] & i_req_wdata[0];
                            r_stop  <= i_req_wdata[2];
                        end
                    end
                    A_INACT:  r_inact  <= merge64(r_inact, i_req_wdata, i_req_dw, w_hi);
                    A_INTR:   r_intr   <= merge64(r_intr, i_req_wdata, i_req_dw, w_hi);
                    A_SWTEST: r_swtest <= merge64(r_swtest, i_req_wdata, i_req_dw, w_hi);
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_tag     = r_rsp_tag;
    assign o_ctl_rst_n   = r_ctl[0];
    assign o_start_pulse = r_start;
    assign o_stop_pulse  = r_stop;
    assign o_cfg_src     = r_src;
    assign o_cfg_dst     = r_dst;
    assign o_cfg_lines   = r_lines[19:0];
    assign o_cfg_cfg     = r_cfg[31:0];
    assign o_cfg_stride  = r_stride[31:0];

endmodule

// File: tb/tb_he_lb_csr_responder.sv
// Directed bench for he_lb_csr_responder: hand-computed expectations,
// inputs driven and outputs sampled on the falling clock edge.
module tb_he_lb_csr_responder;

    localparam logic [63:0] DFH   = 64'h1000_0000_0000_1000;
    localparam logic [63:0] STAT0 = 64'hA5A5_0000_1111_2222;
    localparam logic [63:0] STAT1 = 64'h0BAD_CAFE_3333_4444;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_dw;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic [9:0]  req_tag;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic [9:0]  rsp_tag;
    logic        eng_busy, eng_err;
    logic [63:0] eng_status0, eng_status1;
    logic        ctl_rst_n, start_pulse, stop_pulse;
    logic [63:0] cfg_src, cfg_dst;
    logic [19:0] cfg_lines;
    logic [31:0] cfg_cfg, cfg_stride;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    he_lb_csr_responder dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_dw      (req_dw),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_tag     (req_tag),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_data    (rsp_data),
        .o_rsp_tag     (rsp_tag),
        .i_eng_busy    (eng_busy),
        .i_eng_status0 (eng_status0),
        .i_eng_status1 (eng_status1),
        .i_eng_err     (eng_err),
        .o_ctl_rst_n   (ctl_rst_n),
        .o_start_pulse (start_pulse),
        .o_stop_pulse  (stop_pulse),
        .o_cfg_src     (cfg_src),
        .o_cfg_dst     (cfg_dst),
        .o_cfg_lines   (cfg_lines),
        .o_cfg_cfg     (cfg_cfg),
        .o_cfg_stride  (cfg_stride)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one write; returns on the falling edge after the accepting edge
    task automatic do_write(input logic [11:0] a, input logic dw, input logic [63:0] d);
        @(negedge clk);
        chk("wr_ready", {63'h0, req_ready}, 64'h1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_dw    = dw;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // one read, checked for latency 1, data and tag, then completed
    task automatic do_read(input string nm, input logic [11:0] a, input logic dw,
                           input logic [9:0] tg, input logic [63:0] exp);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_dw    = dw;
        req_addr  = a;
        req_tag   = tg;
        @(negedge clk);
        req_valid = 1'b0;
        chk({nm, "_valid"}, {63'h0, rsp_valid}, 64'h1);
        chk(nm, rsp_data, exp);
        chk({nm, "_tag"}, {54'h0, rsp_tag}, {54'h0, tg});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_done"}, {63'h0, rsp_valid}, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_dw = 1'b0;
        req_addr = 12'h000; req_wdata = 64'h0; req_tag = 10'h000;
        rsp_ready = 1'b0; eng_busy = 1'b0; eng_err = 1'b0;
        eng_status0 = STAT0; eng_status1 = STAT1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rst_rsp_data", rsp_data, 64'h0);
        chk("rst_ctl_rst_n", {63'h0, ctl_rst_n}, 64'h0);
        chk("rst_start", {63'h0, start_pulse}, 64'h0);
        chk("rst_lines", {44'h0, cfg_lines}, 64'h0);
        rst = 1'b0;

        // 1: DFH read
        do_read("dfh", 12'h000, 1'b0, 10'h2A5, DFH);
        do_read("id_l", 12'h008, 1'b0, 10'h001, 64'h0);

        // 2: scratchpad 4B write/read, neighbours untouched
        do_write(12'h104, 1'b1, 64'h0000_0000_DEAD_BEEF);
        do_read("scr1", 12'h104, 1'b1, 10'h003, 64'h0000_0000_DEAD_BEEF);
        do_read("scr0", 12'h100, 1'b1, 10'h004, 64'h0);
        do_read("scr2", 12'h108, 1'b1, 10'h005, 64'h0);
        do_read("scr1_8b_hi", 12'h104, 1'b0, 10'h006, 64'h0);

        // 3: back-pressured completion, second request held off
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_dw = 1'b1;
        req_addr = 12'h104; req_tag = 10'h005;
        @(negedge clk);
        req_dw = 1'b0; req_addr = 12'h000; req_tag = 10'h006;
        chk("bp_valid", {63'h0, rsp_valid}, 64'h1);
        chk("bp_data", rsp_data, 64'h0000_0000_DEAD_BEEF);
        chk("bp_tag", {54'h0, rsp_tag}, 64'h5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {63'h0, rsp_valid}, 64'h1);
            chk("bp_hold_data", rsp_data, 64'h0000_0000_DEAD_BEEF);
            chk("bp_hold_tag", {54'h0, rsp_tag}, 64'h5);
            chk("bp_hold_ready", {63'h0, req_ready}, 64'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_gap_valid", {63'h0, rsp_valid}, 64'h0);
        chk("bp_gap_ready", {63'h0, req_ready}, 64'h1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp2_valid", {63'h0, rsp_valid}, 64'h1);
        chk("bp2_data", rsp_data, DFH);
        chk("bp2_tag", {54'h0, rsp_tag}, 64'h6);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp2_done", {63'h0, rsp_valid}, 64'h0);

        // 4: CTL strobes
        do_write(12'h138, 1'b0, 64'h3);
        chk("ctl3_rst_n", {63'h0, ctl_rst_n}, 64'h1);
        chk("ctl3_start", {63'h0, start_pulse}, 64'h1);
        chk("ctl3_stop", {63'h0, stop_pulse}, 64'h0);
        @(negedge clk);
        chk("ctl3_start_end", {63'h0, start_pulse}, 64'h0);
        do_write(12'h138, 1'b0, 64'h5);
        chk("ctl5_stop", {63'h0, stop_pulse}, 64'h1);
        chk("ctl5_start", {63'h0, start_pulse}, 64'h0);
        @(negedge clk);
        chk("ctl5_stop_end", {63'h0, stop_pulse}, 64'h0);
        do_write(12'h138, 1'b0, 64'h1);
        chk("ctl1_start", {63'h0, start_pulse}, 64'h0);
        chk("ctl1_rst_n", {63'h0, ctl_rst_n}, 64'h1);
        do_read("ctl_rd", 12'h138, 1'b0, 10'h007, 64'h1);

        // 5: busy gating of NUM_LINES
        eng_busy = 1'b1;
        do_write(12'h130, 1'b0, 64'd16);
        chk("lines_busy", {44'h0, cfg_lines}, 64'h0);
        eng_busy = 1'b0;
        do_write(12'h130, 1'b0, 64'd16);
        chk("lines_idle", {44'h0, cfg_lines}, 64'd16);

        // half writes, misaligned 8B access
        do_write(12'h124, 1'b1, 64'hFFFF_FFFF_1234_5678);
        chk("src_hi", cfg_src, 64'h1234_5678_0000_0000);
        do_write(12'h12C, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("dst_bad8", cfg_dst, 64'h0);
        do_read("src_lo4", 12'h120, 1'b1, 10'h008, 64'h0);
        do_read("src_hi4", 12'h124, 1'b1, 10'h009, 64'h0000_0000_1234_5678);
        do_read("src_bad8", 12'h124, 1'b0, 10'h00A, 64'h0);
        do_read("stat0", 12'h160, 1'b0, 10'h00B, STAT0);
        do_read("stat1_hi", 12'h16C, 1'b1, 10'h00C, 64'h0000_0000_0BAD_CAFE);

        // 6: ERROR set wins over same-cycle clear, then clears
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_dw = 1'b0;
        req_addr = 12'h170; req_wdata = 64'h1; eng_err = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; eng_err = 1'b0;
        do_read("err_set", 12'h170, 1'b0, 10'h00D, 64'h1);
        do_write(12'h170, 1'b0, 64'h1);
        do_read("err_clr", 12'h170, 1'b0, 10'h00E, 64'h0);
        do_read("unmapped", 12'h180, 1'b0, 10'h3FF, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
